// File: rtl/user_au_iir1_stage.sv
// First-order IIR audio stage with per-channel state on a time-interleaved stream.
// Coefficients, enable/clear and the saturation counter sit behind an OBI subordinate port.

package obi_pkg;
  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [0:0]  aid;
    logic        a_optional;
  } obi_a_chan_t;

  typedef struct packed {
    obi_a_chan_t a;
    logic        req;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [0:0]  rid;
    logic        err;
    logic        r_optional;
  } obi_r_chan_t;

  typedef struct packed {
    obi_r_chan_t r;
    logic        gnt;
    logic        rvalid;
  } obi_rsp_t;
endpackage

module user_au_iir1_stage #(
  parameter obi_pkg::obi_cfg_t ObiCfg = obi_pkg::ObiDefaultConfig,
  parameter type obi_req_t   = obi_pkg::obi_req_t,
  parameter type obi_rsp_t   = obi_pkg::obi_rsp_t,
  parameter int  DataWidth   = 32,
  parameter int  CoefWidth   = 16,
  parameter int  CoefFrac    = 11,
  parameter int  NumChannels = 2,
  parameter int  ChanWidth   = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  obi_req_t             obi_req_i,
  output obi_rsp_t             obi_rsp_o,
  input  logic [DataWidth-1:0] data_i,
  input  logic [ChanWidth-1:0] ch_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [DataWidth-1:0] data_o,
  output logic [ChanWidth-1:0] ch_o,
  output logic                 valid_o,
  input  logic                 ready_i
);

  localparam int AccWidth = DataWidth + CoefWidth + 2;
  localparam int RegDW    = int'(ObiCfg.DataWidth);
  localparam logic [DataWidth-1:0] SatMax = {1'b0, {(DataWidth-1){1'b1}}};
  localparam logic [DataWidth-1:0] SatMin = {1'b1, {(DataWidth-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_e;
  state_e state_q, state_d;

  // ---------------- OBI register file ----------------
  logic                        wr, clr_wr, sat_wr, sat_inc;
  logic [2:0]                  idx;
  logic                        enable_q;
  logic signed [CoefWidth-1:0] b0_q, b1_q, a1_q;
  logic [15:0]                 sat_cnt_q;
  logic [RegDW-1:0]            rd_data, rdata_q;
  logic                        rvalid_q, err_q;
  logic [$bits(obi_req_i.a.aid)-1:0] rid_q;
  logic                        unused_ok;

  assign idx       = obi_req_i.a.addr[4:2];
  assign wr        = obi_req_i.req & obi_req_i.a.we;
  assign clr_wr    = wr && (idx == 3'd0) && obi_req_i.a.wdata[1];
  assign sat_wr    = wr && (idx == 3'd4);
  assign unused_ok = ^obi_req_i;

  always_comb begin
    rd_data = '0;
    case (idx)
      3'd0:    rd_data = RegDW'(enable_q);
      3'd1:    rd_data = RegDW'(b0_q);
      3'd2:    rd_data = RegDW'(b1_q);
      3'd3:    rd_data = RegDW'(a1_q);
      3'd4:    rd_data = RegDW'(sat_cnt_q);
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      enable_q  <= 1'b0;
      b0_q      <= CoefWidth'(1 << CoefFrac);
      b1_q      <= '0;
      a1_q      <= '0;
      sat_cnt_q <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
    end else begin
      if (wr) begin
        case (idx)
          3'd0:    enable_q <= obi_req_i.a.wdata[0];
          3'd1:    b0_q     <= obi_req_i.a.wdata[CoefWidth-1:0];
          3'd2:    b1_q     <= obi_req_i.a.wdata[CoefWidth-1:0];
          3'd3:    a1_q     <= obi_req_i.a.wdata[CoefWidth-1:0];
          default: ;
        endcase
      end
      // a software clear beats a concurrent saturation increment
      if (sat_wr)                        sat_cnt_q <= '0;
      else if (sat_inc && ~&sat_cnt_q)   sat_cnt_q <= sat_cnt_q + 16'd1;
      rvalid_q <= obi_req_i.req;
      rid_q    <= obi_req_i.a.aid;
      err_q    <= obi_req_i.req && (idx > 3'd4);
      rdata_q  <= rd_data;
    end
  end

  always_comb begin
    obi_rsp_o              = '0;
    obi_rsp_o.gnt          = obi_req_i.req;
    obi_rsp_o.rvalid       = rvalid_q;
    obi_rsp_o.r.rdata      = rdata_q;
    obi_rsp_o.r.rid        = rid_q;
    obi_rsp_o.r.err        = err_q;
    obi_rsp_o.r.r_optional = 1'b0;
  end

  // ---------------- sample FSM ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_i) state_d = CALC;
      CALC:    state_d = OUT;
      OUT:     if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ready_o = (state_q == IDLE) && !rst_i;
  assign valid_o = (state_q == OUT) && !rst_i;

  // ---------------- datapath ----------------
  logic signed [DataWidth-1:0] x_q;
  logic [ChanWidth-1:0]        ch_q;
  logic signed [CoefWidth-1:0] b0_s, b1_s, a1_s;
  logic                        en_s, drop_q, ch_ok;
  logic signed [DataWidth-1:0] x_prev [NumChannels];
  logic signed [DataWidth-1:0] y_prev [NumChannels];
  logic signed [DataWidth-1:0] xp, yp;
  logic signed [AccWidth-1:0]  p0, p1, p2, acc, sh;
  logic [AccWidth-DataWidth:0] hi;
  logic                        ovf;
  logic [DataWidth-1:0]        res;

  assign ch_ok = int'(ch_q) < NumChannels;
  assign xp    = ch_ok ? x_prev[ch_q] : '0;
  assign yp    = ch_ok ? y_prev[ch_q] : '0;
  assign p0    = AccWidth'(b0_s) * AccWidth'(x_q);
  assign p1    = AccWidth'(b1_s) * AccWidth'(xp);
  assign p2    = AccWidth'(a1_s) * AccWidth'(yp);
  assign acc   = p0 + p1 - p2;
  assign sh    = acc >>> CoefFrac;
  // result fits only when every bit above the sample MSB matches the sign
  assign hi    = sh[AccWidth-1:DataWidth-1];
  assign ovf   = !((&hi) || !(|hi));
  assign res   = (!en_s || !ch_ok) ? x_q :
                 ovf ? (sh[AccWidth-1] ? SatMin : SatMax) : sh[DataWidth-1:0];
  assign sat_inc = (state_q == CALC) && en_s && ch_ok && ovf;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q    <= '0;
      ch_q   <= '0;
      b0_s   <= '0;
      b1_s   <= '0;
      a1_s   <= '0;
      en_s   <= 1'b0;
      drop_q <= 1'b0;
      data_o <= '0;
      ch_o   <= '0;
      for (int i = 0; i < NumChannels; i++) begin
        x_prev[i] <= '0;
        y_prev[i] <= '0;
      end
    end else begin
      if (state_q == IDLE && valid_i) begin
        x_q    <= data_i;
        ch_q   <= ch_i;
        b0_s   <= b0_q;
        b1_s   <= b1_q;
        a1_s   <= a1_q;
        en_s   <= enable_q;
        drop_q <= 1'b0;
      end else if (clr_wr && state_q != IDLE) begin
        drop_q <= 1'b1;
      end
      if (state_q == CALC) begin
        data_o <= res;
        ch_o   <= ch_q;
      end
      if (clr_wr) begin
        for (int i = 0; i < NumChannels; i++) begin
          x_prev[i] <= '0;
          y_prev[i] <= '0;
        end
      end else if (state_q == OUT && ready_i && ch_ok && !drop_q) begin
        x_prev[ch_q] <= x_q;
        y_prev[ch_q] <= data_o;
      end
    end
  end

endmodule
